// File: rtl/sseg_display_sched_if.sv
// Request/acknowledge bundle between the result sources and the display scheduler.
// Requester k drives req[k] and its signed value at val[k*W +: W].
interface sseg_display_sched_if #(
  parameter int NREQ = 2,
  parameter int W    = 19
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] val;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;

  modport master (output req, output val, input ack, input grant);
  modport slave  (input req, input val, output ack, output grant);
endinterface

// File: rtl/sseg_display_sched.sv
// Round-robin display scheduler: captures one requester's signed value, converts it to
// sign + 3 BCD digits with a 10-cycle double-dabble, then holds and scans it on the 4-digit display.
// Optional build macro SSEG_LEADING_BLANK_EN enables leading-zero suppression.
module sseg_display_sched #(
  parameter int NREQ        = 2,
  parameter int W           = 19,
  parameter int HOLD_CYCLES = 50000000,
  parameter int REFRESH_BIT = 18
) (
  input  logic                 clk1,
  input  logic                 reset1,
  sseg_display_sched_if.slave  dsp,
  output logic                 busy,
  output logic                 ovf,
  output logic [6:0]           seg1,
  output logic [3:0]           an1
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int CW = REFRESH_BIT + 2;
  localparam int MW = (W + 1 > 10) ? W + 1 : 10;
  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SHOW} state_t;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_rr;
  logic [NREQ-1:0] r_ack, r_grant;
  logic [9:0]      r_bin;
  logic [11:0]     r_bcd;
  logic [3:0]      r_iter;
  logic            r_sign_c, r_ovf_c;
  logic [HW-1:0]   r_hold;
  logic [CW-1:0]   r_cnt;
  logic            r_disp_valid, r_dsign, r_ovf;
  logic [3:0]      r_d2, r_d1, r_d0;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [W-1:0]    w_val_sel;
  logic [W:0]      w_ext, w_mag;
  logic [MW-1:0]   w_magx;
  logic            w_neg, w_sat;
  logic [9:0]      w_bin_load;
  logic [NREQ-1:0] w_onehot;
  logic [11:0]     w_adj, w_nbcd;
  logic [9:0]      w_nbin;
  logic [3:0]      w_h, w_t;
  logic            w_conv_last, w_hold_last;
  logic [1:0]      w_scan;

  // Search upward from rr+1 so the most recent owner has lowest priority.
  always_comb begin
    logic [PW-1:0] cand;
    int unsigned   idx;
    w_found   = 1'b0;
    w_win     = '0;
    w_val_sel = '0;
    cand      = '0;
    idx       = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx  = (32'(r_rr) + i) % NREQ;
      cand = PW'(idx);
      if (!w_found && dsp.req[cand]) begin
        w_found = 1'b1;
        w_win   = cand;
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_win == PW'(k)) w_val_sel = dsp.val[k*W +: W];
    end
  end

  // Magnitude is formed one bit wider so the most negative value is exact.
  assign w_neg      = w_val_sel[W-1];
  assign w_ext      = {w_val_sel[W-1], w_val_sel};
  assign w_mag      = w_neg ? -w_ext : w_ext;
  assign w_magx     = MW'(w_mag);
  assign w_sat      = (w_magx > MW'(999));
  assign w_bin_load = w_sat ? 10'd999 : w_magx[9:0];
  assign w_onehot   = NREQ'(1) << w_win;

  always_comb begin
    w_adj = '0;
    for (int unsigned j = 0; j < 3; j++) begin
      w_adj[4*j +: 4] = (r_bcd[4*j +: 4] >= 4'd5) ? r_bcd[4*j +: 4] + 4'd3 : r_bcd[4*j +: 4];
    end
  end

  assign w_nbcd = {w_adj[10:0], r_bin[9]};
  assign w_nbin = {r_bin[8:0], 1'b0};

`ifdef SSEG_LEADING_BLANK_EN
  assign w_h = (w_nbcd[11:8] == 4'd0) ? BLANK : w_nbcd[11:8];
  assign w_t = (w_nbcd[11:8] == 4'd0 && w_nbcd[7:4] == 4'd0) ? BLANK : w_nbcd[7:4];
`else
  assign w_h = w_nbcd[11:8];
  assign w_t = w_nbcd[7:4];
`endif

  assign w_conv_last = (r_iter == 4'd0);
  assign w_hold_last = (r_hold == HW'(HOLD_CYCLES - 1));

  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_found) w_next = S_CONV;
      S_CONV: begin
        busy = 1'b1;
        if (w_conv_last) w_next = S_SHOW;
      end
      S_SHOW: begin
        busy = 1'b1;
        if (w_hold_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      r_rr         <= PW'(NREQ - 1);
      r_ack        <= '0;
      r_grant      <= '0;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_iter       <= '0;
      r_sign_c     <= 1'b0;
      r_ovf_c      <= 1'b0;
      r_hold       <= '0;
      r_cnt        <= '0;
      r_disp_valid <= 1'b0;
      r_dsign      <= 1'b0;
      r_ovf        <= 1'b0;
      r_d2         <= '0;
      r_d1         <= '0;
      r_d0         <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ack    <= w_onehot;
            r_grant  <= w_onehot;
            r_rr     <= w_win;
            r_sign_c <= w_neg;
            r_ovf_c  <= w_sat;
            r_bin    <= w_bin_load;
            r_bcd    <= '0;
            r_iter   <= 4'd9;
          end
        end
        S_CONV: begin
          r_bcd  <= w_nbcd;
          r_bin  <= w_nbin;
          r_iter <= r_iter - 4'd1;
          if (w_conv_last) begin
            r_disp_valid <= 1'b1;
            r_dsign      <= r_sign_c;
            r_ovf        <= r_ovf_c;
            r_d2         <= w_h;
            r_d1         <= w_t;
            r_d0         <= w_nbcd[3:0];
            r_hold       <= '0;
          end
        end
        S_SHOW: begin
          r_hold <= r_hold + 1'b1;
          if (w_hold_last) r_grant <= '0;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = 7'b1111111;
    endcase
  endfunction

  assign w_scan = r_cnt[CW-1:CW-2];

  always_comb begin
    an1  = 4'b1111;
    seg1 = 7'b1111111;
    if (r_disp_valid) begin
      case (w_scan)
        2'd0: begin an1 = 4'b1110; seg1 = f_seg(r_d0); end
        2'd1: begin an1 = 4'b1101; seg1 = f_seg(r_d1); end
        2'd2: begin an1 = 4'b1011; seg1 = f_seg(r_d2); end
        default: begin an1 = 4'b0111; seg1 = r_dsign ? 7'b0111111 : 7'b1111111; end
      endcase
    end
  end

  assign ovf       = r_ovf;
  assign dsp.ack   = r_ack;
  assign dsp.grant = r_grant;

endmodule

// File: tb/tb_sseg_display_sched.sv
// Scoreboard bench for sseg_display_sched: stimulus queues expected ack/grant/display records,
// a monitor pops one per ack pulse and checks handshake timing and the scanned digits.
module tb_sseg_display_sched;
  localparam int NREQ = 2;
  localparam int W    = 19;

`ifdef SSEG_LEADING_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  typedef struct {
    logic [1:0] ack;
    logic [1:0] grant;
    int         gap;
    bit         chk;
    logic [6:0] s0, s1, s2, s3;
    logic       ov;
  } exp_t;

  logic       clk1 = 1'b0;
  logic       reset1;
  logic       busy, ovf;
  logic [6:0] seg1;
  logic [3:0] an1;

  sseg_display_sched_if #(.NREQ(NREQ), .W(W)) dsp ();

  sseg_display_sched #(.NREQ(NREQ), .W(W), .HOLD_CYCLES(4), .REFRESH_BIT(2)) dut (
    .clk1(clk1), .reset1(reset1), .dsp(dsp), .busy(busy), .ovf(ovf), .seg1(seg1), .an1(an1)
  );

  always #5 clk1 = ~clk1;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_pushed = 0;
  int   mon_done = 0;
  int   last_cyc = 0;
  exp_t sb[$];
  exp_t m_e;

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  task automatic push(input logic [1:0] a, input int gap, input bit c,
                      input logic [6:0] s0, s1, s2, s3, input logic ov);
    exp_t e;
    e.ack = a; e.grant = a; e.gap = gap; e.chk = c;
    e.s0 = s0; e.s1 = s1; e.s2 = s2; e.s3 = s3; e.ov = ov;
    sb.push_back(e);
    n_pushed++;
  endtask

  task automatic wait_ack();
    bit got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk1);
      if (dsp.ack !== 2'b00) got = 1;
    end
    if (!got) timeout_fail("wait_ack");
  endtask

  task automatic wait_mon();
    bit got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk1);
      if (mon_done >= n_pushed) got = 1;
    end
    if (!got) timeout_fail("wait_monitor");
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk1);
      if (busy === 1'b0) got = 1;
    end
    if (!got) timeout_fail("wait_idle");
  endtask

  task automatic run_disp(input logic [18:0] v, input logic [6:0] s0, s1, s2, s3, input logic ov);
    @(negedge clk1);
    dsp.val[18:0] = v;
    dsp.req       = 2'b01;
    push(2'b01, 0, 1'b1, s0, s1, s2, s3, ov);
    wait_ack();
    dsp.req = 2'b00;
    wait_mon();
    wait_idle();
  endtask

  // Monitor: one scoreboard record per ack pulse.
  initial begin : monitor
    logic [6:0] want;
    bit         okpos;
    forever begin
      @(negedge clk1);
      if (dsp.ack !== 2'b00) begin
        if (sb.size() == 0) begin
          timeout_fail("unexpected_ack");
          $display("FAIL unexpected_ack: got %0b want none", dsp.ack);
        end else begin
          m_e = sb.pop_front();
          chk("ack", dsp.ack, m_e.ack);
          chk("grant", dsp.grant, m_e.grant);
          if (m_e.gap != 0) chk("ack_gap", cyc - last_cyc, m_e.gap);
          last_cyc = cyc;
          @(negedge clk1);
          chk("ack_width", dsp.ack, 2'b00);
          chk("busy_conv", busy, 1'b1);
          if (m_e.chk) begin
            repeat (9) @(negedge clk1);
            chk("ovf", ovf, m_e.ov);
            for (int k = 0; k < 16; k++) begin
              okpos = 1'b1;
              want  = 7'h7F;
              case (an1)
                4'b1110: want = m_e.s0;
                4'b1101: want = m_e.s1;
                4'b1011: want = m_e.s2;
                4'b0111: want = m_e.s3;
                default: okpos = 1'b0;
              endcase
              if (okpos) chk($sformatf("seg_an%04b", an1), seg1, want);
              else       chk("an1_scan", an1, 4'b1110);
              if (k < 15) @(negedge clk1);
            end
          end
          mon_done++;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset1   = 1'b1;
    dsp.req  = '0;
    dsp.val  = '0;
    repeat (3) @(negedge clk1);
    chk("rst_seg", seg1, 7'h7F);
    chk("rst_an", an1, 4'hF);
    chk("rst_ack", dsp.ack, 2'b00);
    chk("rst_grant", dsp.grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    reset1 = 1'b0;
    repeat (20) @(negedge clk1);
    chk("idle_seg", seg1, 7'h7F);
    chk("idle_an", an1, 4'hF);
    chk("idle_busy", busy, 1'b0);

    // ones, tens, hundreds, sign
    run_disp(-19'sd123,    7'h30, 7'h24, 7'h79, 7'h3F, 1'b0);
    run_disp(19'sd5000,    7'h10, 7'h10, 7'h10, 7'h7F, 1'b1);
    run_disp(-19'sd262144, 7'h10, 7'h10, 7'h10, 7'h3F, 1'b1);
    run_disp(19'sd7,       7'h78, LZ,    LZ,    7'h7F, 1'b0);
    run_disp(19'sd45,      7'h12, 7'h19, LZ,    7'h7F, 1'b0);
    run_disp(19'sd0,       7'h40, LZ,    LZ,    7'h7F, 1'b0);
    run_disp(19'sd999,     7'h10, 7'h10, 7'h10, 7'h7F, 1'b0);
    run_disp(19'sd1000,    7'h10, 7'h10, 7'h10, 7'h7F, 1'b1);
    run_disp(-19'sd5,      7'h12, LZ,    LZ,    7'h3F, 1'b0);

    // Abort during conversion: reset 5 edges after capture.
    @(negedge clk1);
    dsp.val[18:0] = -19'sd321;
    dsp.req       = 2'b01;
    push(2'b01, 0, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    wait_ack();
    dsp.req = 2'b00;
    repeat (5) @(posedge clk1);
    #1 reset1 = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_an", an1, 4'hF);
    chk("abort_seg", seg1, 7'h7F);
    chk("abort_grant", dsp.grant, 2'b00);
    chk("abort_ovf", ovf, 1'b0);
    repeat (2) @(negedge clk1);
    reset1 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk1);
      chk("abort_an_hold", an1, 4'hF);
      chk("abort_no_ack", dsp.ack, 2'b00);
    end

    // Round-robin with both requesters held continuously after reset.
    @(negedge clk1);
    dsp.val[18:0]  = 19'sd11;
    dsp.val[37:19] = 19'sd22;
    dsp.req        = 2'b11;
    push(2'b01, 0,  1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    push(2'b10, 15, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    push(2'b01, 15, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    push(2'b10, 15, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    wait_mon();
    dsp.req = 2'b00;
    wait_idle();
    repeat (20) @(negedge clk1);
    chk("sb_empty", sb.size(), 0);
    chk("end_grant", dsp.grant, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
